vend_dispenser: RTL

VEND_DISPENSER -- requirements
Module: vend_dispenser

---
 rtl/vend_dispenser_pkg.sv | 28 ++
 rtl/vend_dispenser.sv | 85 ++++++++
 2 files changed

// File: rtl/vend_dispenser_pkg.sv
// Shared types and constants for the vend dispenser: FSM state encoding,
// counter widths and the saturating stock adder.
package vend_dispenser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam int STOCK_W  = 4;
    localparam int PEND_W   = 2;
    localparam int PEND_MAX = 3;
    localparam int TIMER_W  = 4;

    localparam logic [STOCK_W-1:0] STOCK_MAX = 4'd15;

    // One extra bit keeps the carry so the clamp sees the true sum.
    function automatic logic [STOCK_W-1:0] stock_sat_add(
        input logic [STOCK_W-1:0] a,
        input logic [STOCK_W-1:0] b
    );
        logic [STOCK_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, STOCK_MAX}) ? STOCK_MAX : sum[STOCK_W-1:0];
    endfunction

endpackage

// File: rtl/vend_dispenser.sv
// Dispense controller: queues up to three accepted requests, runs the motor
// for MOTOR_CYCLES per item, then settles one cycle and retires the item.
module vend_dispenser
    import vend_dispenser_pkg::*;
#(
    parameter int STOCK_INIT   = 8,
    parameter int MOTOR_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_valid,
    input  logic               io_restock,
    input  logic [STOCK_W-1:0] io_restock_count,
    output logic               io_motor,
    output logic               io_done,
    output logic               io_refund,
    output logic               io_empty,
    output logic [STOCK_W-1:0] io_stock,
    output logic [PEND_W-1:0]  io_pending
);

    state_e               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [PEND_W-1:0]    r_pending;
    logic [STOCK_W-1:0]   r_stock;
    logic                 r_motor;

    state_e               w_state_nxt;
    logic                 w_room;
    logic                 w_accept;
    logic                 w_settle;
    logic                 w_restock;

    // Acceptance uses the registered (pre-settle, pre-restock) counters.
    assign w_room    = (r_pending < PEND_W'(PEND_MAX)) &&
                       ({{(STOCK_W-PEND_W){1'b0}}, r_pending} < r_stock);
    assign w_accept  = io_valid && !reset && w_room;
    assign w_settle  = (r_state == SETTLE);
    assign w_restock = io_restock && (r_state == IDLE) && (r_pending == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_pending != '0) w_state_nxt = RUN;
            RUN:     if (r_timer == '0)   w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_pending <= '0;
            r_stock   <= STOCK_W'(STOCK_INIT);
            r_motor   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_motor <= (w_state_nxt == RUN);

            if (r_state == IDLE && r_pending != '0)
                r_timer <= TIMER_W'(MOTOR_CYCLES - 1);
            else if (r_state == RUN && r_timer != '0)
                r_timer <= r_timer - 1'b1;

            // Accept and settle in the same cycle cancel out.
            r_pending <= r_pending + PEND_W'(w_accept) - PEND_W'(w_settle);

            // Restock needs IDLE, so it can never collide with a settle.
            if (w_settle)
                r_stock <= r_stock - 1'b1;
            else if (w_restock)
                r_stock <= stock_sat_add(r_stock, io_restock_count);
        end
    end

    assign io_motor   = r_motor;
    assign io_done    = w_settle;
    assign io_refund  = io_valid && !reset && !w_room;
    assign io_empty   = (r_stock == '0);
    assign io_stock   = r_stock;
    assign io_pending = r_pending;

endmodule
